// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO.
// A stored word is {last, data}: the end-of-frame flag sits just above the payload.
package pkt_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2048;

  function automatic int word_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/pkt_fifo_if.sv
// Push port (frame writer) and FWFT read port of pkt_fifo, bundled for connection.
interface pkt_fifo_if
  import pkt_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_last;
  logic             wr_drop;
  logic             full;
  logic             drop_pulse;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready;
  logic             frame_avail;

  modport master (
    output wr_en, wr_data, wr_last, wr_drop, m_ready,
    input  full, drop_pulse, m_valid, m_data, m_last, frame_avail
  );

  modport slave (
    input  wr_en, wr_data, wr_last, wr_drop, m_ready,
    output full, drop_pulse, m_valid, m_data, m_last, frame_avail
  );

endinterface

// File: rtl/pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset so it maps to block RAM.
module pkt_fifo_sdp_ram
  import pkt_fifo_pkg::*;
#(
  parameter int W     = DEF_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Read data only changes on re, so an unconsumed word is held in rdata_q.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward byte FIFO: frames become readable only once committed by wr_last;
// wr_drop or an overflow rewinds the write pointer to the last commit point.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  pkt_fifo_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          WW      = word_w(WIDTH);
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_P   = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      wr_cmt_q, wr_cmt_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic             ram_vld_q, ram_vld_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;

  logic             full;
  logic             discard;
  logic             wr_fire;
  logic             commit;
  logic             readable;
  logic             out_load;
  logic             rd_fire;
  logic             pop_last;
  logic [WW-1:0]    ram_rdata;

  always_comb begin
    full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    // A wr_last that arrives while full, or on a frame that already lost a word, cannot commit.
    discard  = bus.wr_drop | (bus.wr_en & bus.wr_last & (ovf_q | full));
    wr_fire  = bus.wr_en & ~full & ~ovf_q & ~discard;
    commit   = wr_fire & bus.wr_last;

    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    ovf_d    = ovf_q;
    if (discard) begin
      wr_ptr_d = wr_cmt_q;
      ovf_d    = 1'b0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + ONE_P;
      if (commit) wr_cmt_d = wr_ptr_q + ONE_P;
      if (bus.wr_en & full) ovf_d = 1'b1;
    end
    drop_d = discard;

    // Two-stage FWFT: RAM read register feeds the output register; both advance together.
    readable  = rd_ptr_q != wr_cmt_q;
    out_load  = ram_vld_q & (~m_valid_q | bus.m_ready);
    rd_fire   = readable & (~ram_vld_q | out_load);
    rd_ptr_d  = rd_fire ? rd_ptr_q + ONE_P : rd_ptr_q;
    ram_vld_d = rd_fire | (ram_vld_q & ~out_load);

    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (out_load) begin
      m_valid_d = 1'b1;
      m_last_d  = ram_rdata[WIDTH];
      m_data_d  = ram_rdata[WIDTH-1:0];
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    pop_last = m_valid_q & bus.m_ready & m_last_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, commit} - {{AW{1'b0}}, pop_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      wr_cmt_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      ram_vld_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_cmt_q  <= wr_cmt_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      ram_vld_q <= ram_vld_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  pkt_fifo_sdp_ram #(
    .W     (WW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({bus.wr_last, bus.wr_data}),
    .re    (rd_fire),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.full        = full;
  assign bus.drop_pulse  = drop_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign bus.m_last      = m_last_q;
  assign bus.frame_avail = cnt_q != '0;

endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: directed timing checks plus randomized frames against a queue-based frame model.
module tb_pkt_fifo;
  import pkt_fifo_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int DEPTH = 64;

  logic clk;
  logic rst_n;

  pkt_fifo_if #(.WIDTH(WIDTH)) bus ();

  pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_drop_seen = 0;
  int n_drop_exp = 0;
  int n_cmt_words = 0;
  logic [8:0] exp_q[$];
  logic [7:0] fbuf[128];
  bit rand_ready = 1'b0;
  bit ready_force = 1'b0;
  bit prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reader: random or forced m_ready, updated 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    bus.m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_force;
  end

  // Monitor: decides acceptances at the falling edge, between driver updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(bus.m_valid), 1);
        check("stall_word", int'({bus.m_last, bus.m_data}), int'(prev_word));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_without_expected_word", exp_q.size(), 1);
        end else begin
          check("beat", int'({bus.m_last, bus.m_data}), int'(exp_q.pop_front()));
          n_acc++;
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_word  = {bus.m_last, bus.m_data};
      if (bus.drop_pulse) n_drop_seen++;
    end
  end

  task automatic push(input logic [7:0] d, input logic last, input logic drop);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_last = last;
    bus.wr_drop = drop;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
    bus.wr_drop = 1'b0;
  endtask

  // Sends fbuf[0:len-1]; drop_at >= 0 aborts with wr_drop on that byte.
  task automatic send_frame(input int len, input int drop_at);
    for (int i = 0; i < len; i++) begin
      if (i == drop_at) begin
        push(fbuf[i], 1'b0, 1'b1);
        n_drop_exp++;
        return;
      end
      push(fbuf[i], i == len - 1, 1'b0);
    end
    for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, fbuf[i]});
    n_cmt_words += len;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_full"}, int'(bus.full), 0);
    check({tag, "_drop_pulse"}, int'(bus.drop_pulse), 0);
    check({tag, "_m_valid"}, int'(bus.m_valid), 0);
    check({tag, "_m_data"}, int'(bus.m_data), 0);
    check({tag, "_m_last"}, int'(bus.m_last), 0);
    check({tag, "_frame_avail"}, int'(bus.frame_avail), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.wr_last = 1'b0;
    bus.wr_drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    ready_force = 1'b1;
    @(posedge clk); #1;

    // 64-byte frame fills the FIFO exactly; streams out 2 cycles after commit.
    for (int i = 0; i < 64; i++) fbuf[i] = 8'(i);
    send_frame(64, -1);
    check("t1_avail_after_commit", int'(bus.frame_avail), 1);
    check("t1_valid_n1", int'(bus.m_valid), 0);
    check("t1_full", int'(bus.full), 1);
    @(posedge clk); #1;
    check("t1_valid_n2", int'(bus.m_valid), 0);
    @(posedge clk); #1;
    check("t1_valid_n3", int'(bus.m_valid), 1);
    for (int i = 0; i < 64; i++) begin
      check("t1_contiguous", int'(bus.m_valid), 1);
      @(posedge clk); #1;
    end
    check("t1_avail_done", int'(bus.frame_avail), 0);
    check("t1_valid_done", int'(bus.m_valid), 0);

    // Aborted frame then a short good frame.
    for (int i = 0; i < 10; i++) fbuf[i] = 8'(8'h10 + i);
    send_frame(10, 4);
    check("t2_drop_pulse", int'(bus.drop_pulse), 1);
    @(posedge clk); #1;
    check("t2_drop_pulse_width", int'(bus.drop_pulse), 0);
    fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC; fbuf[3] = 8'hDD;
    send_frame(4, -1);
    wait_drain();
    check("t2_avail", int'(bus.frame_avail), 0);

    // Overflow with the reader idle: 70-byte frame into 64 words.
    ready_force = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 70; i++) begin
      if (i == 63) check("t3_not_full_63", int'(bus.full), 0);
      if (i == 64) check("t3_full_64", int'(bus.full), 1);
      push(8'(i), i == 69, 1'b0);
    end
    n_drop_exp++;
    check("t3_drop_pulse", int'(bus.drop_pulse), 1);
    check("t3_full_cleared", int'(bus.full), 0);
    check("t3_avail", int'(bus.frame_avail), 0);
    repeat (4) @(posedge clk);
    #1;
    check("t3_valid_empty", int'(bus.m_valid), 0);
    check("t3_avail_empty", int'(bus.frame_avail), 0);

    // Commit of B on the edge that accepts A's last byte.
    fbuf[0] = 8'hA0; fbuf[1] = 8'hA1; fbuf[2] = 8'hA2;
    send_frame(3, -1);
    begin
      int c = 0;
      while (!bus.m_valid && c < 20) begin
        @(posedge clk); #1;
        c++;
      end
      check("t4_a_visible", int'(bus.m_valid), 1);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(8'(8'hB0 + i), 1'b0, 1'b0);
    ready_force = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_avail_before", int'(bus.frame_avail), 1);
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, 8'(8'hB0 + i)});
    n_cmt_words += 5;
    push(8'hB4, 1'b1, 1'b0);
    check("t4_avail_same_edge", int'(bus.frame_avail), 1);
    check("t4_a_gone", int'(bus.m_valid), 0);
    @(posedge clk); #1;
    check("t4_b_not_yet", int'(bus.m_valid), 0);
    @(posedge clk); #1;
    check("t4_b_visible", int'(bus.m_valid), 1);
    wait_drain();

    // Random frames, random reader, occasional aborts, many pointer wraps.
    rand_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int len;
      int drop_at;
      int c;
      len = $urandom_range(1, 60);
      drop_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom);
      c = 0;
      while ((n_cmt_words - n_acc) + len > DEPTH && c < 5000) begin
        @(posedge clk); #1;
        c++;
      end
      if (c == 5000) check("space_wait", c, 0);
      send_frame(len, drop_at);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();
    check("rand_avail", int'(bus.frame_avail), 0);

    // Asynchronous reset in the middle of a read.
    rand_ready = 1'b0;
    ready_force = 1'b1;
    for (int i = 0; i < 20; i++) fbuf[i] = 8'(8'h40 + i);
    send_frame(20, -1);
    repeat (6) @(posedge clk);
    #1;
    check("t6_mid_read", int'(bus.m_valid), 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("async_rst");
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_valid_after", int'(bus.m_valid), 0);
    check("t6_avail_after", int'(bus.frame_avail), 0);
    for (int i = 0; i < 8; i++) fbuf[i] = 8'(8'h80 + i);
    send_frame(8, -1);
    wait_drain();
    check("t6_avail_done", int'(bus.frame_avail), 0);

    check("drop_count", n_drop_seen, n_drop_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
